// File: rtl/rand_uart_tx.sv
// -----------------------------------------------------------------------------
// rand_uart_tx
//
// Buffers random bytes from the PRNG stage in a 4-entry FIFO and serializes
// them as UART 8N1 frames (start 0, 8 data bits LSB first, stop 1). Frames
// are sent back-to-back while bytes are available and en is high.
//
// Parameters
//   CLK_HZ     system clock frequency in Hz
//   BAUD       serial bit rate; DIV = CLK_HZ/BAUD cycles per bit (DIV >= 2)
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   en         allows a new frame to start; a running frame always completes
//   in_data    byte to buffer
//   in_valid   in_data is valid
//   in_ready   FIFO can accept a byte (count < 4)
//   tx         serial line, idle high, registered
//   busy       frame in progress, registered
//   fifo_count bytes held in the FIFO, 0..4
// -----------------------------------------------------------------------------
module rand_uart_tx #(
    parameter int CLK_HZ = 10_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic [2:0] fifo_count
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [CNT_W-1:0] w_baud_cnt_nx;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_nx;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nx;
    logic             r_tx;
    logic             w_tx_nx;
    logic             r_busy;
    logic             w_busy_nx;
    logic             w_pop;

    logic [7:0]       r_mem [4];
    logic [1:0]       r_wptr;
    logic [1:0]       r_rptr;
    logic [2:0]       r_count;
    logic             w_push;
    logic             w_can_start;
    logic             w_baud_end;

    // No bypass: a full FIFO refuses a byte even when a pop happens this cycle.
    assign in_ready    = (r_count < 3'd4);
    assign w_push      = in_valid && in_ready;
    assign w_can_start = en && (r_count != 3'd0);
    assign w_baud_end  = (r_baud_cnt == CNT_LAST);

    assign tx          = r_tx;
    assign busy        = r_busy;
    assign fifo_count  = r_count;

    // FIFO storage and the serializer byte carry no reset; they are only
    // read after being written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
        r_shift <= w_shift_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_baud_cnt <= w_baud_cnt_nx;
            r_bit_idx  <= w_bit_idx_nx;
            r_tx       <= w_tx_nx;
            r_busy     <= w_busy_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_baud_cnt_nx = r_baud_cnt;
        w_bit_idx_nx  = r_bit_idx;
        w_shift_nx    = r_shift;
        w_tx_nx       = r_tx;
        w_busy_nx     = r_busy;
        w_pop         = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_baud_cnt_nx = '0;
                w_bit_idx_nx  = 3'd0;
                w_tx_nx       = 1'b1;
                w_busy_nx     = 1'b0;
                if (w_can_start) begin
                    w_pop      = 1'b1;
                    w_shift_nx = r_mem[r_rptr];
                    w_state_nx = S_START;
                    w_tx_nx    = 1'b0;
                    w_busy_nx  = 1'b1;
                end
            end

            S_START: begin
                if (w_baud_end) begin
                    w_baud_cnt_nx = '0;
                    w_bit_idx_nx  = 3'd0;
                    w_state_nx    = S_DATA;
                    w_tx_nx       = r_shift[0];
                end else begin
                    w_baud_cnt_nx = r_baud_cnt + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_cnt_nx = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nx = S_STOP;
                        w_tx_nx    = 1'b1;
                    end else begin
                        // Shift right so the next bit to send is always bit 0.
                        w_bit_idx_nx = r_bit_idx + 3'd1;
                        w_shift_nx   = {1'b0, r_shift[7:1]};
                        w_tx_nx      = r_shift[1];
                    end
                end else begin
                    w_baud_cnt_nx = r_baud_cnt + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_cnt_nx = '0;
                    w_bit_idx_nx  = 3'd0;
                    // Chain straight into the next start bit when allowed,
                    // so consecutive frames have no idle gap.
                    if (w_can_start) begin
                        w_pop      = 1'b1;
                        w_shift_nx = r_mem[r_rptr];
                        w_state_nx = S_START;
                        w_tx_nx    = 1'b0;
                        w_busy_nx  = 1'b1;
                    end else begin
                        w_state_nx = S_IDLE;
                        w_tx_nx    = 1'b1;
                        w_busy_nx  = 1'b0;
                    end
                end else begin
                    w_baud_cnt_nx = r_baud_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nx = S_IDLE;
                w_tx_nx    = 1'b1;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rand_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_rand_uart_tx
//
// Bench for rand_uart_tx at CLK_HZ=10 MHz, BAUD=1 MHz (10 cycles per bit).
// Single-frame vectors come from a table of {byte, expected 10-bit line
// pattern}; FIFO fill, back-to-back, en drop, coincident push/pop and
// asynchronous reset are exercised by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_rand_uart_tx;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int n_vec;
    int n_err;

    rand_uart_tx #(
        .CLK_HZ(10_000_000),
        .BAUD  (1_000_000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx        (tx),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line pattern index 0 is the start bit, 1..8 data LSB first, 9 stop.
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        en       = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("reset tx", {31'd0, tx}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset count", {29'd0, fifo_count}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
    endtask

    // Called at the negedge just after the start edge. Checks the 100 cycles
    // of one frame ({busy,tx} per cycle, one comparison per bit period).
    // Optionally drives one push at sample push_at and drops en at en_off_at.
    task automatic run_frame(input string name, input logic [9:0] exp,
                             input int push_at, input logic [7:0] push_d,
                             input int en_off_at);
        logic       bad;
        logic [1:0] obs;
        for (int k = 0; k < 10; k++) begin
            bad = 1'b0;
            obs = {1'b1, exp[k]};
            for (int c = 0; c < 10; c++) begin
                if (({busy, tx} !== {1'b1, exp[k]}) && !bad) begin
                    bad = 1'b1;
                    obs = {busy, tx};
                end
                if ((k * 10 + c) == push_at) begin
                    in_valid = 1'b1;
                    in_data  = push_d;
                end else begin
                    in_valid = 1'b0;
                end
                if ((k * 10 + c) == en_off_at) begin
                    en = 1'b0;
                end
                @(negedge clk);
            end
            check($sformatf("%s bit%0d {busy,tx}", name, k), {30'd0, obs}, {30'd0, 1'b1, exp[k]});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;

        tbl[0] = '{data: 8'hA5, frame: 10'b1101001010};
        tbl[1] = '{data: 8'h00, frame: 10'b1000000000};
        tbl[2] = '{data: 8'hFF, frame: 10'b1111111110};
        tbl[3] = '{data: 8'h3C, frame: 10'b1001111000};
        tbl[4] = '{data: 8'h81, frame: 10'b1100000010};

        // ---------------- single frames from an empty FIFO ----------------
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = tbl[i].data;
            @(negedge clk);
            // Push edge N: byte stored, line still idle.
            check($sformatf("v%0d idle tx after push", i), {31'd0, tx}, 32'd1);
            check($sformatf("v%0d count after push", i), {29'd0, fifo_count}, 32'd1);
            check($sformatf("v%0d busy after push", i), {31'd0, busy}, 32'd0);
            in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d count after pop", i), {29'd0, fifo_count}, 32'd0);
            run_frame($sformatf("v%0d", i), tbl[i].frame, -1, 8'h00, -1);
            check($sformatf("v%0d busy at end", i), {31'd0, busy}, 32'd0);
            check($sformatf("v%0d tx at end", i), {31'd0, tx}, 32'd1);
        end

        // ---------------- fill while disabled, then back-to-back ----------------
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            @(negedge clk);
        end
        check("fill count", {29'd0, fifo_count}, 32'd4);
        check("fill in_ready", {31'd0, in_ready}, 32'd0);
        check("fill tx idle", {31'd0, tx}, 32'd1);
        en = 1'b1;
        @(negedge clk);
        // Full at this edge: pop only, 0x05 not taken.
        check("b2b first pop count", {29'd0, fifo_count}, 32'd3);
        check("b2b in_ready after pop", {31'd0, in_ready}, 32'd1);
        run_frame("b2b 01", 10'b1000000010, 0, 8'h05, -1);
        check("b2b count after 01", {29'd0, fifo_count}, 32'd3);
        run_frame("b2b 02", 10'b1000000100, -1, 8'h00, -1);
        check("b2b count after 02", {29'd0, fifo_count}, 32'd2);
        run_frame("b2b 03", 10'b1000000110, -1, 8'h00, -1);
        check("b2b count after 03", {29'd0, fifo_count}, 32'd1);
        run_frame("b2b 04", 10'b1000001000, -1, 8'h00, -1);
        check("b2b count after 04", {29'd0, fifo_count}, 32'd0);
        run_frame("b2b 05", 10'b1000001010, -1, 8'h00, -1);
        check("b2b busy at end", {31'd0, busy}, 32'd0);
        check("b2b tx at end", {31'd0, tx}, 32'd1);

        // ---------------- en dropped during data bits ----------------
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'h11;
        @(negedge clk);
        in_data  = 8'h22;
        @(negedge clk);
        in_valid = 1'b0;
        en = 1'b1;
        @(negedge clk);
        run_frame("endrop 11", 10'b1000100010, -1, 8'h00, 30);
        check("endrop busy", {31'd0, busy}, 32'd0);
        check("endrop tx", {31'd0, tx}, 32'd1);
        check("endrop count", {29'd0, fifo_count}, 32'd1);
        repeat (20) @(negedge clk);
        check("endrop still idle", {29'd0, fifo_count, busy, tx}, {29'd0, 3'd1, 1'b0, 1'b1});

        // ---------------- push coinciding with pop at stop end ----------------
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'h22;
        @(negedge clk);
        in_data  = 8'h33;
        @(negedge clk);
        in_valid = 1'b0;
        en = 1'b1;
        @(negedge clk);
        check("pushpop count in 22", {29'd0, fifo_count}, 32'd1);
        run_frame("pushpop 22", 10'b1001000100, 99, 8'h44, -1);
        check("pushpop count held", {29'd0, fifo_count}, 32'd1);
        run_frame("pushpop 33", 10'b1001100110, -1, 8'h00, -1);
        check("pushpop count after 33", {29'd0, fifo_count}, 32'd0);
        run_frame("pushpop 44", 10'b1010001000, -1, 8'h00, -1);
        check("pushpop idle", {29'd0, fifo_count, busy, tx}, {29'd0, 3'd0, 1'b0, 1'b1});

        // ---------------- asynchronous reset mid-frame ----------------
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h10 + 8'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        en = 1'b1;
        @(negedge clk);
        repeat (30) @(negedge clk);
        check("arst pre count", {29'd0, fifo_count}, 32'd3);
        check("arst pre busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        // Still 2 ns before the next rising edge.
        check("arst tx", {31'd0, tx}, 32'd1);
        check("arst busy", {31'd0, busy}, 32'd0);
        check("arst count", {29'd0, fifo_count}, 32'd0);
        check("arst in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst      = 1'b0;
        en       = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(negedge clk);
        check("arst first push", {29'd0, fifo_count}, 32'd1);
        check("arst tx after", {31'd0, tx}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
